// File: rtl/instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_buffer
// Purpose  : Circular FIFO of fetched {PC, instruction, fetch-exception}
//            entries between the I-cache response path and the ID pipeline
//            register. It decouples cache-return timing from decode stalls
//            (ID_Wr) and pipeline flushes (ID_Flush).
// Ports    : clk, resetn        - clock, asynchronous active-low reset
//            Fetch_Valid/Instr/PC/Except - incoming cache response
//            Buf_Ready          - a push can be accepted this cycle
//            ID_Wr, ID_Flush    - head consume, discard all entries
//            IF_Valid/Instr/PC/ExceptType - head entry (zeros when invalid)
//            Buf_Count          - current occupancy
// Options  : IFB_BYPASS_EN - when the buffer is empty, an incoming fetch is
//            presented combinationally on the head outputs.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_buffer #(
    parameter int DEPTH = 4  // power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     Fetch_Valid,
    input  logic [31:0]              Fetch_Instr,
    input  logic [31:0]              Fetch_PC,
    input  logic [2:0]               Fetch_Except,
    output logic                     Buf_Ready,
    input  logic                     ID_Wr,
    input  logic                     ID_Flush,
    output logic                     IF_Valid,
    output logic [31:0]              IF_Instr,
    output logic [31:0]              IF_PC,
    output logic [2:0]               IF_ExceptType,
    output logic [$clog2(DEPTH):0]   Buf_Count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // Entry layout: {PC[66:35], instr[34:3], except[2:0]}
    logic [66:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_bypass_take;
    logic [66:0] w_head;

    assign w_empty   = (r_count == '0);
    assign Buf_Ready = (r_count != c_FULL);   // registered state only
    assign Buf_Count = r_count;
    assign w_head    = r_mem[r_rd_ptr];

`ifdef IFB_BYPASS_EN
    // Empty buffer, word arriving and ID consuming: hand it straight through
    // without occupying a slot.
    assign w_bypass_take = w_empty && Fetch_Valid && ID_Wr && !ID_Flush;
`else
    assign w_bypass_take = 1'b0;
`endif

    assign w_push = Fetch_Valid && Buf_Ready && !ID_Flush && !w_bypass_take;
    // Only stored entries can be popped; a bypassed word never entered storage.
    assign w_pop  = ID_Wr && !w_empty && !ID_Flush;

    // Storage has no reset: contents are only observed when r_count != 0.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {Fetch_PC, Fetch_Instr, Fetch_Except};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (ID_Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head outputs: stored head when occupied; zeros (nop) otherwise.
    always_comb begin
        IF_Valid      = 1'b0;
        IF_PC         = 32'h0;
        IF_Instr      = 32'h0;
        IF_ExceptType = 3'b000;
        if (!ID_Flush) begin
            if (!w_empty) begin
                IF_Valid      = 1'b1;
                IF_PC         = w_head[66:35];
                IF_Instr      = w_head[34:3];
                IF_ExceptType = w_head[2:0];
            end
`ifdef IFB_BYPASS_EN
            else if (Fetch_Valid) begin
                IF_Valid      = 1'b1;
                IF_PC         = Fetch_PC;
                IF_Instr      = Fetch_Instr;
                IF_ExceptType = Fetch_Except;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_buffer
// Purpose  : Self-checking bench for instr_fetch_buffer (DEPTH=4). A queue
//            holds the entries the buffer should contain; every cycle the
//            head outputs, occupancy and ready flag are compared with it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_buffer;

    localparam int c_DEPTH = 4;
`ifdef IFB_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  exc;
    } ent_t;

    logic        clk;
    logic        resetn;
    logic        Fetch_Valid;
    logic [31:0] Fetch_Instr;
    logic [31:0] Fetch_PC;
    logic [2:0]  Fetch_Except;
    logic        Buf_Ready;
    logic        ID_Wr;
    logic        ID_Flush;
    logic        IF_Valid;
    logic [31:0] IF_Instr;
    logic [31:0] IF_PC;
    logic [2:0]  IF_ExceptType;
    logic [2:0]  Buf_Count;

    ent_t q[$];
    int   n_checks;
    int   n_fail;
    bit   accepted;

    instr_fetch_buffer #(.DEPTH(c_DEPTH)) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .Fetch_Valid  (Fetch_Valid),
        .Fetch_Instr  (Fetch_Instr),
        .Fetch_PC     (Fetch_PC),
        .Fetch_Except (Fetch_Except),
        .Buf_Ready    (Buf_Ready),
        .ID_Wr        (ID_Wr),
        .ID_Flush     (ID_Flush),
        .IF_Valid     (IF_Valid),
        .IF_Instr     (IF_Instr),
        .IF_PC        (IF_PC),
        .IF_ExceptType(IF_ExceptType),
        .Buf_Count    (Buf_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    // One cycle: drive after the rising edge, check on the falling edge,
    // then advance the reference queue to what the next edge should produce.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [2:0] exc,
                        input logic wr, input logic fl);
        ent_t exp_head;
        ent_t inc;
        logic exp_v;
        int   pre;
        @(posedge clk);
        #1;
        Fetch_Valid  = fv;
        Fetch_PC     = pc;
        Fetch_Instr  = mk_instr(pc);
        Fetch_Except = exc;
        ID_Wr        = wr;
        ID_Flush     = fl;
        @(negedge clk);
        inc   = '{pc: pc, instr: mk_instr(pc), exc: exc};
        pre   = q.size();
        exp_v = !fl && (pre != 0 || (c_BYP && fv));
        exp_head = (pre != 0) ? q[0] : inc;
        if (!exp_v) exp_head = '0;
        chk("if_valid", {63'd0, IF_Valid}, {63'd0, exp_v});
        chk("buf_count", {61'd0, Buf_Count}, 64'(pre));
        chk("buf_ready", {63'd0, Buf_Ready}, {63'd0, pre != c_DEPTH});
        chk("if_pc", {32'd0, IF_PC}, {32'd0, exp_head.pc});
        chk("if_instr", {32'd0, IF_Instr}, {32'd0, exp_head.instr});
        chk("if_except", {61'd0, IF_ExceptType}, {61'd0, exp_head.exc});
        accepted = fv && !fl && (pre != c_DEPTH);
        if (fl) begin
            q.delete();
        end else begin
            if (wr && pre != 0) void'(q.pop_front());
            // A word consumed through the bypass in an empty cycle is not stored.
            if (accepted && !(pre == 0 && wr && exp_v)) q.push_back(inc);
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] pc;
        int guard;
        n_checks = 0;
        n_fail   = 0;
        accepted = 1'b0;
        resetn = 1'b0;
        Fetch_Valid = 1'b0; Fetch_PC = '0; Fetch_Instr = '0; Fetch_Except = '0;
        ID_Wr = 1'b0; ID_Flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, IF_Valid}, 64'd0);
        chk("rst_ready", {63'd0, Buf_Ready}, 64'd1);
        chk("rst_count", {61'd0, Buf_Count}, 64'd0);
        chk("rst_pc", {32'd0, IF_PC}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Fill with ID stalled, then offer a fifth word that must be refused.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 3'b000, 1'b0, 1'b0);
        step(1'b1, 32'h110, 3'b000, 1'b0, 1'b0);
        chk("full_refuse", {63'd0, accepted}, 64'd0);

        // Sustained push+pop through pointer wrap; refused words re-presented.
        pc = 32'h110;
        guard = 0;
        while (pc < 32'h120 && guard < 40) begin
            step(1'b1, pc, 3'b000, 1'b1, 1'b0);
            if (accepted) pc += 32'd4;
            guard++;
        end
        chk("wrap_push_done", {32'd0, pc}, 64'h120);
        repeat (6) step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);  // drain, then pop on empty

        // Flush colliding with a push: 0x200 must never surface.
        step(1'b1, 32'h1F0, 3'b000, 1'b0, 1'b0);
        step(1'b1, 32'h1F4, 3'b000, 1'b0, 1'b0);
        step(1'b1, 32'h200, 3'b000, 1'b0, 1'b1);
        step(1'b1, 32'h204, 3'b000, 1'b0, 1'b0);
        step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
        idle();

        // Exception flags travel with their entry.
        step(1'b1, 32'hBFC0_0001, 3'b100, 1'b0, 1'b0);
        step(1'b1, 32'hBFC0_0005, 3'b011, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

        // Empty buffer with a word arriving while ID consumes.
        step(1'b1, 32'h300, 3'b000, 1'b1, 1'b0);
        repeat (2) step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
        step(1'b1, 32'h304, 3'b010, 1'b0, 1'b0);
        repeat (2) step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

        // Random traffic.
        pc = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), pc, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            if (accepted) pc += 32'd4;
        end
        repeat (5) step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

        // Asynchronous reset with three entries held.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 3'b001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        Fetch_Valid = 1'b0; ID_Wr = 1'b0; ID_Flush = 1'b0;
        #1;
        chk("pre_rst_count", {61'd0, Buf_Count}, 64'd3);
        resetn = 1'b0;
        #1;
        chk("async_valid", {63'd0, IF_Valid}, 64'd0);
        chk("async_pc", {32'd0, IF_PC}, 64'd0);
        chk("async_instr", {32'd0, IF_Instr}, 64'd0);
        chk("async_except", {61'd0, IF_ExceptType}, 64'd0);
        chk("async_count", {61'd0, Buf_Count}, 64'd0);
        chk("async_ready", {63'd0, Buf_Ready}, 64'd1);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle();
        step(1'b1, 32'h600, 3'b000, 1'b0, 1'b0);
        repeat (2) step(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
